// File: rtl/uart_pkg.sv
// Shared state encoding and framing constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FETCH = 3'd3,
        ST_ISSUE = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_e;

    localparam logic [7:0] FRAME_DELIM    = 8'h26;
    localparam int         FRAME_OVERHEAD = 4;

    // Total bytes on the wire for a payload of len bytes; 9 bits so 255+4 fits.
    function automatic logic [8:0] frame_total(input logic [7:0] len);
        return {1'b0, len} + 9'(FRAME_OVERHEAD);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester above last_winner, wrapping, as a one-hot vector.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] winner
);

    always_comb begin
        logic [LW:0] cand;
        logic        found;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_winner} + (LW+1)'(i);
            if (cand >= (LW+1)'(NUM_REQ)) begin
                cand = cand - (LW+1)'(NUM_REQ);
            end
            if (!found && req[cand[LW-1:0]]) begin
                winner[cand[LW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters; each grant sends
// "&&" + payload + "&&", fetching payload bytes one at a time from the owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TX_TIMEOUT_CLK = 50_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_len,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 rd_en,
    output logic [7:0]           rd_idx,
    input  logic [NUM_REQ*8-1:0] rd_data,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 busy,
    output logic [7:0]           utx_data,
    output logic                 utx_req,
    input  logic                 utx_done,
    output logic [2:0]           dbg_state
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TX_TIMEOUT_CLK) + 1;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [LW-1:0]        owner_q, owner_d;
    logic [LW-1:0]        last_q, last_d;
    logic [7:0]           len_q, len_d;
    logic [8:0]           k_q, k_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [7:0]           utx_data_q, utx_data_d;

    logic [NUM_REQ-1:0]   winner;
    logic [LW-1:0]        win_idx;
    logic [7:0]           win_len;
    logic [7:0]           rd_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LW      (LW)
    ) u_rr (
        .req         (req),
        .last_winner (last_q),
        .winner      (winner)
    );

    always_comb begin
        win_idx = '0;
        win_len = '0;
        rd_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_idx = LW'(i);
                win_len = req_len[8*i +: 8];
            end
            if (owner_q == LW'(i)) begin
                rd_byte = rd_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_q     <= LW'(NUM_REQ - 1);
            len_q      <= '0;
            k_q        <= '0;
            tmo_q      <= '0;
            utx_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            len_q      <= len_d;
            k_q        <= k_d;
            tmo_q      <= tmo_d;
            utx_data_q <= utx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_d     = last_q;
        len_d      = len_q;
        k_d        = k_q;
        tmo_d      = tmo_q;
        utx_data_d = utx_data_q;
        rd_en      = 1'b0;
        rd_idx     = '0;
        utx_req    = 1'b0;
        done       = '0;
        err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Requests may have vanished since IDLE; fall back rather than grant nobody.
                if (|winner) begin
                    grant_d = winner;
                    owner_d = win_idx;
                    len_d   = win_len;
                    k_d     = '0;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if ((k_q < 9'd2) || (k_q >= {1'b0, len_q} + 9'd2)) begin
                    utx_data_d = FRAME_DELIM;
                    state_d    = ST_ISSUE;
                end else begin
                    rd_en   = 1'b1;
                    rd_idx  = 8'(k_q - 9'd2);
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                utx_data_d = rd_byte;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                utx_req = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion landing on the timeout cycle still counts as success.
                tmo_d = tmo_q + TW'(1);
                if (utx_done) begin
                    k_d     = k_q + 9'd1;
                    state_d = (k_q + 9'd1 == frame_total(len_q)) ? ST_DONE : ST_LOAD;
                end else if (tmo_d == TW'(TX_TIMEOUT_CLK - 1)) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                done    = grant_q;
                grant_d = '0;
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err     = 1'b1;
                done    = grant_q;
                grant_d = '0;
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant     = grant_q;
    assign utx_data  = utx_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a UART/payload model answers the DUT,
// monitors log bytes, strobes and grants, and each test task checks its own results.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 100;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_len;
    logic [NUM_REQ-1:0]   grant;
    logic                 rd_en;
    logic [7:0]           rd_idx;
    logic [NUM_REQ*8-1:0] rd_data;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic                 busy;
    logic [7:0]           utx_data;
    logic                 utx_req;
    logic                 utx_done;
    logic [2:0]           dbg_state;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TX_TIMEOUT_CLK (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .req_len   (req_len),
        .grant     (grant),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .utx_data  (utx_data),
        .utx_req   (utx_req),
        .utx_done  (utx_done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- models and logs ----------------
    logic [7:0] mem [NUM_REQ][256];
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] idx_log[$];
    logic [3:0] done_log[$];
    logic [3:0] grant_hist[$];
    int         rd_en_cnt, err_cnt, req_cyc, err_cyc, done_cyc;
    int         resp_lat;
    logic       resp_en;
    int         n_chk = 0;
    int         n_fail = 0;

    initial begin
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 256; j++)
                mem[i][j] = 8'(8'h61 + 16*i + j);
    end

    // UART transmitter and payload source, both reacting at the falling edge.
    initial begin : utx_model
        int         cnt;
        logic       pend;
        logic [7:0] pend_idx;
        cnt = 0; pend = 1'b0; pend_idx = '0;
        utx_done = 1'b0;
        rd_data  = {NUM_REQ{8'hEE}};
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                cnt = 0; pend = 1'b0; utx_done = 1'b0;
                rd_data = {NUM_REQ{8'hEE}};
            end else begin
                if (pend) begin
                    for (int i = 0; i < NUM_REQ; i++) rd_data[8*i +: 8] = mem[i][pend_idx];
                end else begin
                    rd_data = {NUM_REQ{8'hEE}};
                end
                pend = rd_en;
                pend_idx = rd_idx;
                utx_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) utx_done = 1'b1;
                end
                if (utx_req) begin
                    tx_log.push_back(utx_data);
                    req_cyc = cyc;
                    if (resp_en) cnt = resp_lat;
                end
            end
        end
    end

    initial begin : monitor
        logic [3:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(negedge sys_clk);
            if (rd_en) begin rd_en_cnt++; idx_log.push_back(rd_idx); end
            if (|done) begin done_log.push_back(done); done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (grant != prev_grant && grant != '0) grant_hist.push_back(grant);
            prev_grant = grant;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        tx_log.delete(); exp_q.delete(); idx_log.delete();
        done_log.delete(); grant_hist.delete();
        rd_en_cnt = 0; err_cnt = 0; req_cyc = 0; err_cyc = 0; done_cyc = 0;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk); #1;
        sys_rst = 1'b1;
        req     = '0;
        repeat (2) @(negedge sys_clk);
        #1;
        sys_rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_dones(input int n, input int budget);
        while (done_log.size() < n && budget > 0) begin
            @(negedge sys_clk); #1;
            budget--;
        end
    endtask

    task automatic exp_frame(input int r, input int len);
        exp_q.push_back(FRAME_DELIM);
        exp_q.push_back(FRAME_DELIM);
        for (int j = 0; j < len; j++) exp_q.push_back(mem[r][j]);
        exp_q.push_back(FRAME_DELIM);
        exp_q.push_back(FRAME_DELIM);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_chk++;
        if ({grant, done, rd_en, rd_idx, err, busy, utx_data, utx_req} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {grant, done, rd_en, rd_idx, err, busy, utx_data, utx_req});
        end
        n_chk++;
        if (dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
    endtask

    task automatic test_single_frame();
        int nbad;
        clear_logs();
        resp_en = 1'b1; resp_lat = 10;
        req_len[7:0] = 8'd3;
        req = 4'b0001;
        wait_dones(1, 400);
        req = '0;
        repeat (3) @(negedge sys_clk);
        exp_q.push_back(8'h26); exp_q.push_back(8'h26);
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
        exp_q.push_back(8'h26); exp_q.push_back(8'h26);
        n_chk++; nbad = 0;
        if (tx_log.size() != exp_q.size()) nbad++;
        else foreach (exp_q[i]) if (tx_log[i] !== exp_q[i]) nbad++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL single_bytes: got %0d bytes (%0d wrong), want %0d", tx_log.size(), nbad, exp_q.size());
        end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 4'b0001) begin
            n_fail++; $display("FAIL single_done: got %0d pulses first %b, want 1 pulse 0001", done_log.size(), done_log[0]);
        end
        n_chk++;
        if (idx_log.size() != 3 || idx_log[0] !== 8'd0 || idx_log[1] !== 8'd1 || idx_log[2] !== 8'd2) begin
            n_fail++; $display("FAIL single_rd_idx: got %0d fetches, want indices 0,1,2", idx_log.size());
        end
        n_chk++;
        if (err_cnt != 0) begin
            n_fail++; $display("FAIL single_err: got %0d err pulses want 0", err_cnt);
        end
    endtask

    task automatic test_len_zero();
        int nbad;
        clear_logs();
        resp_lat = 3;
        req_len[15:8] = 8'd0;
        req = 4'b0010;
        wait_dones(1, 200);
        req = '0;
        repeat (3) @(negedge sys_clk);
        repeat (4) exp_q.push_back(8'h26);
        n_chk++; nbad = 0;
        if (tx_log.size() != exp_q.size()) nbad++;
        else foreach (exp_q[i]) if (tx_log[i] !== exp_q[i]) nbad++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL len0_bytes: got %0d bytes (%0d wrong), want 4 x 26", tx_log.size(), nbad);
        end
        n_chk++;
        if (rd_en_cnt != 0) begin
            n_fail++; $display("FAIL len0_rd_en: got %0d fetches want 0", rd_en_cnt);
        end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 4'b0010) begin
            n_fail++; $display("FAIL len0_done: got %0d pulses first %b, want 1 pulse 0010", done_log.size(), done_log[0]);
        end
    endtask

    task automatic test_grant_order();
        int nbad;
        apply_reset();
        resp_en = 1'b1; resp_lat = 2;
        req_len = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        wait_dones(5, 600);
        req = '0;
        repeat (3) @(negedge sys_clk);
        n_chk++;
        if (done_log.size() != 5 || done_log[0] !== 4'b0001 || done_log[1] !== 4'b0010 ||
            done_log[2] !== 4'b0100 || done_log[3] !== 4'b1000 || done_log[4] !== 4'b0001) begin
            n_fail++; $display("FAIL rr_done_order: got %0d pulses, want 0001 0010 0100 1000 0001", done_log.size());
        end
        n_chk++;
        if (grant_hist.size() != 5 || grant_hist[0] !== 4'b0001 || grant_hist[1] !== 4'b0010 ||
            grant_hist[2] !== 4'b0100 || grant_hist[3] !== 4'b1000 || grant_hist[4] !== 4'b0001) begin
            n_fail++; $display("FAIL rr_grant_order: got %0d grants, want 0001 0010 0100 1000 0001", grant_hist.size());
        end
        exp_frame(0, 1); exp_frame(1, 1); exp_frame(2, 1); exp_frame(3, 1); exp_frame(0, 1);
        n_chk++; nbad = 0;
        if (tx_log.size() != exp_q.size()) nbad++;
        else foreach (exp_q[i]) if (tx_log[i] !== exp_q[i]) nbad++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL rr_bytes: got %0d bytes (%0d wrong), want %0d", tx_log.size(), nbad, exp_q.size());
        end
    endtask

    task automatic test_owner_drop();
        int nbad;
        int b;
        apply_reset();
        resp_lat = 3;
        req_len[23:16] = 8'd4;
        req_len[15:8]  = 8'd1;
        req = 4'b0100;
        b = 300;
        while (tx_log.size() < 3 && b > 0) begin @(negedge sys_clk); #1; b--; end
        req = 4'b0010;
        wait_dones(2, 600);
        req = '0;
        repeat (3) @(negedge sys_clk);
        n_chk++;
        if (done_log.size() != 2 || done_log[0] !== 4'b0100 || done_log[1] !== 4'b0010) begin
            n_fail++; $display("FAIL drop_done_order: got %0d pulses, want 0100 then 0010", done_log.size());
        end
        n_chk++;
        if (grant_hist.size() != 2 || grant_hist[0] !== 4'b0100 || grant_hist[1] !== 4'b0010) begin
            n_fail++; $display("FAIL drop_grants: got %0d grants, want 0100 then 0010", grant_hist.size());
        end
        exp_frame(2, 4); exp_frame(1, 1);
        n_chk++; nbad = 0;
        if (tx_log.size() != exp_q.size()) nbad++;
        else foreach (exp_q[i]) if (tx_log[i] !== exp_q[i]) nbad++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL drop_bytes: got %0d bytes (%0d wrong), want %0d", tx_log.size(), nbad, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int nbad;
        // Completion arriving exactly on the last allowed cycle must still succeed.
        clear_logs();
        resp_en = 1'b1; resp_lat = TMO - 1;
        req_len[31:24] = 8'd0;
        req = 4'b1000;
        wait_dones(1, 1000);
        req = '0;
        repeat (3) @(negedge sys_clk);
        n_chk++;
        if (err_cnt != 0 || done_log.size() != 1 || done_log[0] !== 4'b1000) begin
            n_fail++; $display("FAIL edge_done_wins: got %0d err, %0d done, want 0 err 1 done", err_cnt, done_log.size());
        end
        repeat (4) exp_q.push_back(8'h26);
        n_chk++; nbad = 0;
        if (tx_log.size() != exp_q.size()) nbad++;
        else foreach (exp_q[i]) if (tx_log[i] !== exp_q[i]) nbad++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL edge_bytes: got %0d bytes (%0d wrong), want 4 x 26", tx_log.size(), nbad);
        end
        // No completion at all: abandon after the timeout.
        clear_logs();
        resp_en = 1'b0;
        req = 4'b1000;
        wait_dones(1, 400);
        req = '0;
        n_chk++;
        if (err_cnt != 1 || err_cyc - req_cyc != TMO) begin
            n_fail++; $display("FAIL tmo_err: got %0d err at +%0d cycles, want 1 at +%0d", err_cnt, err_cyc - req_cyc, TMO);
        end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 4'b1000 || done_cyc != err_cyc) begin
            n_fail++; $display("FAIL tmo_done: got %0d pulses first %b, want 1000 with err", done_log.size(), done_log[0]);
        end
        @(negedge sys_clk); #1;
        n_chk++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_release: got grant %b busy %b, want 0000 0", grant, busy);
        end
        n_chk++;
        if (tx_log.size() != 1) begin
            n_fail++; $display("FAIL tmo_bytes: got %0d bytes sent want 1", tx_log.size());
        end
        resp_en = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_max_len();
        int nbad;
        clear_logs();
        resp_lat = 1;
        req_len[15:8] = 8'd255;
        req = 4'b0010;
        wait_dones(1, 3000);
        req = '0;
        repeat (3) @(negedge sys_clk);
        exp_frame(1, 255);
        n_chk++; nbad = 0;
        if (tx_log.size() != exp_q.size()) nbad++;
        else foreach (exp_q[i]) if (tx_log[i] !== exp_q[i]) nbad++;
        if (nbad != 0) begin
            n_fail++; $display("FAIL max_bytes: got %0d bytes (%0d wrong), want 259", tx_log.size(), nbad);
        end
        n_chk++;
        if (rd_en_cnt != 255 || idx_log.size() != 255 || idx_log[254] !== 8'd254) begin
            n_fail++; $display("FAIL max_fetch: got %0d fetches, want 255 ending at index 254", rd_en_cnt);
        end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 4'b0010 || err_cnt != 0) begin
            n_fail++; $display("FAIL max_done: got %0d done %0d err, want 1 done 0 err", done_log.size(), err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        clear_logs();
        resp_lat = 4;
        req_len[7:0] = 8'd5;
        req = 4'b0001;
        b = 300;
        while (tx_log.size() < 5 && b > 0) begin @(negedge sys_clk); #1; b--; end
        sys_rst = 1'b1;
        req = '0;
        @(negedge sys_clk); #1;
        n_chk++;
        if ({grant, done, rd_en, rd_idx, err, busy, utx_data, utx_req} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0", {grant, done, rd_en, rd_idx, err, busy, utx_data, utx_req});
        end
        n_chk++;
        if (dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL midrst_state: got %0d want 0", dbg_state);
        end
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        n_chk++;
        if (done_log.size() != 0 || err_cnt != 0 || tx_log.size() != 5) begin
            n_fail++; $display("FAIL midrst_abort: got %0d done %0d err %0d bytes, want 0 0 5", done_log.size(), err_cnt, tx_log.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        sys_rst = 1'b1;
        req     = '0;
        req_len = '0;
        resp_en = 1'b1;
        resp_lat = 10;
        rd_en_cnt = 0; err_cnt = 0; req_cyc = 0; err_cyc = 0; done_cyc = 0;
        test_reset();
        test_single_frame();
        test_len_zero();
        test_grant_order();
        test_owner_drop();
        test_timeout();
        test_max_len();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the UART byte transmitter.
REQ-002 SHALL have parameter TX_TIMEOUT_CLK, default 50_000, max clocks allowed between utx_req and utx_done (1 ms at 50 MHz).
REQ-003 SHALL have port sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester frame request, level, held until done.
REQ-006 SHALL have port req_len  in  NUM_REQ*8  per-requester payload length in bytes, requester i at bits [8i+7:8i].
REQ-007 SHALL have port grant  out  NUM_REQ  one-hot owner of the transmitter, held for the whole frame.
REQ-008 SHALL have port rd_en  out  1  one-cycle payload fetch strobe to the granted requester.
REQ-009 SHALL have port rd_idx  out  8  payload byte index, valid with rd_en.
REQ-010 SHALL have port rd_data  in  NUM_REQ*8  per-requester payload byte, valid the cycle after rd_en.
REQ-011 SHALL have port done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port err  out  1  one-cycle pulse on transmitter timeout.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port utx_data  out  8  byte to the UART transmitter.
REQ-015 SHALL have port utx_req  out  1  one-cycle send strobe to the transmitter.
REQ-016 SHALL have port utx_done  in  1  one-cycle byte-complete pulse from the transmitter.

Function
REQ-017 SHALL frame each grant as "&&", then req_len payload bytes, then "&&" (0x26), for a total of req_len+4 bytes.
REQ-018 SHALL implement states IDLE, ARB, LOAD, FETCH, ISSUE, WAIT, DONE, ERR.
REQ-019 IDLE -> ARB SHALL occur when any req bit is high.
REQ-020 ARB SHALL select the winner round-robin, searching from last_winner+1 upward with wrap, then register grant, latch req_len, clear the 9-bit byte counter k, and go to LOAD; grant SHALL be visible one cycle after ARB.
REQ-021 LOAD: for k<2 or k>=len+2, SHALL set utx_data=0x26 and go to ISSUE; otherwise SHALL pulse rd_en with rd_idx=k-2 and go to FETCH.
REQ-022 FETCH SHALL latch the granted requester's rd_data into utx_data and go to ISSUE.
REQ-023 ISSUE SHALL pulse utx_req for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-024 WAIT: on utx_done, SHALL increment k and go to DONE if k+1==len+4, else to LOAD.
REQ-025 WAIT: when the timeout counter reaches TX_TIMEOUT_CLK-1 without utx_done, SHALL go to ERR; if utx_done arrives in that same cycle, utx_done SHALL win.
REQ-026 DONE SHALL pulse done for the granted bit, clear grant, update last_winner, and go to IDLE.
REQ-027 ERR SHALL pulse err and done for the granted bit, clear grant, update last_winner, and go to IDLE; the frame is abandoned.
REQ-028 A req_len of 0 SHALL send "&&&&" (4 bytes) with no rd_en.
REQ-029 A req_len of 255 SHALL send 259 bytes; k SHALL NOT wrap.
REQ-030 Deassertion of the owner's req mid-frame SHALL be ignored and the frame completed; changes to other req bits SHALL NOT affect the current frame.
REQ-031 utx_done outside WAIT SHALL be ignored.
REQ-032 Between frames, IDLE SHALL last at least one cycle.

Reset
REQ-033 On sys_rst, the block SHALL be in IDLE, and grant, done, rd_en, err, utx_req, utx_data, rd_idx, k and the timeout counter SHALL be 0.
REQ-034 On sys_rst, last_winner SHALL be NUM_REQ-1, so that requester 0 wins first.
REQ-035 sys_rst mid-frame SHALL abort the frame with no done or err pulse.

Structure
REQ-036 State encodings, the delimiter constant 0x26 and the frame overhead of 4 SHALL reside in a shared package uart_pkg.
REQ-037 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_winner; output one-hot winner).

Verification
REQ-038 req=0001, len0=3, payload "abc", utx_done 10 cycles after each utx_req -> utx_data sequence 26 26 61 62 63 26 26, then one done[0] pulse.
REQ-039 req=1111 held, all lengths 1 -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-040 len=0 -> 4 utx_req pulses of 0x26, rd_en never high.
REQ-041 TX_TIMEOUT_CLK=100 with utx_done withheld -> err and done pulse on cycle 100 after utx_req; grant=0 the next cycle.
REQ-042 sys_rst asserted during payload byte 2 -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-043 req[2] dropped mid-frame while req[1] rises -> frame 2 completes, then grant=0010.
